// File: rtl/packet_sync_detector_pkg.sv
// dvb_rx_pkg: shared DVB receive constants and sync-detector state encoding
package dvb_rx_pkg;
    localparam int PKT_LEN = 204;
    localparam logic [7:0] SYNC_BYTE = 8'h47;
    localparam logic [7:0] SYNC_INV = 8'hB8;
    localparam int SF_LEN = 8;
    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
endpackage

// File: rtl/packet_sync_detector_if.sv
// packet_sync_detector_if: deinterleaved byte stream in, packet-framed byte stream out
interface packet_sync_detector_if;
    import dvb_rx_pkg::*;
    logic [7:0] data_in;
    logic in_valid;
    logic [7:0] data_out;
    logic out_valid;
    logic sop;
    logic [7:0] byte_idx;
    logic [$clog2(SF_LEN)-1:0] frame_pos;
    logic locked;
    modport master (
        output data_in, in_valid,
        input data_out, out_valid, sop, byte_idx, frame_pos, locked
    );
    modport slave (
        input data_in, in_valid,
        output data_out, out_valid, sop, byte_idx, frame_pos, locked
    );
endinterface

// File: rtl/packet_sync_detector_pkt_pos_counter.sv
// pkt_pos_counter: mod-LEN byte position within a packet, with clear, load-to-1 and enable
module pkt_pos_counter #(
    parameter int LEN = 204
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic load,
    input  logic clr,
    output logic [7:0] pos,
    output logic wrap
);
    localparam logic [7:0] LAST = 8'(LEN - 1);
    assign wrap = pos == 8'd0;
    always_ff @(posedge clk)
        if (!reset || clr) pos <= '0;
        else if (load) pos <= 8'd1;
        else if (en) pos <= pos == LAST ? 8'd0 : pos + 8'd1;
endmodule

// File: rtl/packet_sync_detector.sv
// packet_sync_detector: hunts, verifies and flywheels the 204-byte sync grid, registering the framed stream
module packet_sync_detector
    import dvb_rx_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int UNLOCK_CNT = 3
) (
    input logic clk,
    input logic reset,
    packet_sync_detector_if.slave bus
);
    localparam logic [7:0] LOCK_N = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_CNT);
    state_t state, state_nx;
    logic [7:0] hits, hits_nx, misses, misses_nx, pos;
    logic [2:0] fp_nx;
    logic hit, wrap, pos_en, pos_load, pos_clr;
    assign hit = bus.data_in == SYNC_BYTE || bus.data_in == SYNC_INV;
    pkt_pos_counter #(.LEN(PKT_LEN)) u_pos (
        .clk(clk),
        .reset(reset),
        .en(pos_en),
        .load(pos_load),
        .clr(pos_clr),
        .pos(pos),
        .wrap(wrap)
    );
    always_comb begin
        state_nx = state;
        hits_nx = hits;
        misses_nx = misses;
        pos_en = bus.in_valid && state != SEARCH;
        pos_load = bus.in_valid && state == SEARCH && hit;
        if (bus.in_valid)
            case (state)
                SEARCH: if (hit) begin
                    hits_nx = 8'd1;
                    state_nx = LOCK_N == 8'd1 ? LOCKED : VERIFY;
                end
                VERIFY: if (wrap) begin
                    hits_nx = hits + 8'd1;
                    state_nx = !hit ? SEARCH : hits_nx == LOCK_N ? LOCKED : VERIFY;
                end
                default: if (wrap) begin
                    misses_nx = hit ? 8'd0 : misses + 8'd1;
                    state_nx = misses_nx == UNLOCK_N ? SEARCH : LOCKED;
                end
            endcase
        pos_clr = state_nx == SEARCH;
        fp_nx = pos_clr ? 3'd0
              : pos_en && wrap ? (bus.data_in == SYNC_INV ? 3'd0 : bus.frame_pos + 3'd1)
              : bus.frame_pos;
        if (pos_clr) begin
            hits_nx = 8'd0;
            misses_nx = 8'd0;
        end
    end
    // Outputs describe the byte just consumed, so they follow the state it leads to.
    always_ff @(posedge clk)
        if (!reset) begin
            state <= SEARCH;
            hits <= '0;
            misses <= '0;
            bus.data_out <= '0;
            bus.out_valid <= 1'b0;
            bus.sop <= 1'b0;
            bus.byte_idx <= '0;
            bus.frame_pos <= '0;
            bus.locked <= 1'b0;
        end else begin
            state <= state_nx;
            hits <= hits_nx;
            misses <= misses_nx;
            bus.out_valid <= bus.in_valid && state_nx == LOCKED;
            bus.sop <= bus.in_valid && state_nx == LOCKED && wrap;
            if (bus.in_valid) begin
                bus.data_out <= bus.data_in;
                bus.byte_idx <= pos;
                bus.frame_pos <= fp_nx;
                bus.locked <= state_nx == LOCKED;
            end
        end
endmodule

// File: tb/tb_packet_sync_detector.sv
// tb_packet_sync_detector: vector table, directed corner sequences and random stream against a grid-anchor reference model
module tb_packet_sync_detector;
    import dvb_rx_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    packet_sync_detector_if bus();
    packet_sync_detector dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        bit rn;
        bit v;
        logic [7:0] d;
        bit ov;
        bit sop;
        logic [7:0] idx;
        bit lk;
        logic [7:0] dout;
    } vec_t;
    vec_t tbl[9];

    int errors = 0, checks = 0, cyc = 0;
    int m_n, m_anchor, m_hits, m_misses, m_ref;
    bit m_lk;
    logic [7:0] e_dout, e_idx;
    logic [2:0] e_fp;
    bit e_ov, e_sop, e_lk;
    int sp, phase, bad_lo, bad_hi;
    int n, cnt_a, cnt_b, r;
    logic [7:0] b;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_n = 0; m_anchor = -1; m_hits = 0; m_misses = 0; m_ref = 0; m_lk = 0;
        e_dout = 0; e_idx = 0; e_fp = 0; e_ov = 0; e_sop = 0; e_lk = 0;
    endfunction

    // Grid is an anchor in the valid-byte count; position and superframe index follow arithmetically.
    function automatic void model_step(bit v, logic [7:0] d);
        bit hit, drop;
        int off, p, k;
        e_ov = 0;
        e_sop = 0;
        if (!v) return;
        hit = d == SYNC_BYTE || d == SYNC_INV;
        drop = 0; p = 0; k = 0;
        if (m_anchor < 0) begin
            if (hit) begin
                m_anchor = m_n; m_hits = 1; m_misses = 0; m_ref = 0; m_lk = 0;
            end
        end else begin
            off = m_n - m_anchor;
            p = off % PKT_LEN;
            k = off / PKT_LEN;
            if (p == 0) begin
                if (d == SYNC_INV) m_ref = k;
                if (!m_lk) begin
                    if (hit) begin
                        m_hits++;
                        m_lk = m_hits >= 3;
                    end else drop = 1;
                end else begin
                    m_misses = hit ? 0 : m_misses + 1;
                    drop = m_misses >= 3;
                end
            end
            if (drop) begin
                m_anchor = -1;
                m_lk = 0;
            end
        end
        e_dout = d;
        e_lk = m_lk;
        e_ov = m_lk;
        e_sop = m_lk && p == 0;
        e_idx = 8'(p);
        e_fp = m_anchor < 0 ? 3'd0 : 3'((k - m_ref) % 8);
        m_n++;
    endfunction

    task automatic tick(bit rn, bit v, logic [7:0] d);
        reset = rn;
        bus.in_valid = v;
        bus.data_in = d;
        @(posedge clk);
        #1;
        cyc++;
        if (!rn) model_reset();
        else model_step(v, d);
        check("data_out", bus.data_out, e_dout);
        check("out_valid", bus.out_valid, e_ov);
        check("sop", bus.sop, e_sop);
        check("byte_idx", bus.byte_idx, e_idx);
        check("frame_pos", bus.frame_pos, e_fp);
        check("locked", bus.locked, e_lk);
    endtask

    function automatic logic [7:0] filler();
        logic [7:0] f;
        do f = 8'($urandom); while (f == SYNC_BYTE || f == SYNC_INV);
        return f;
    endfunction

    // Byte sp of a stream whose packets start at phase; packet k%8==2 carries the inverted sync.
    function automatic logic [7:0] gen();
        int o, k;
        logic [7:0] g;
        o = sp - phase;
        k = o / PKT_LEN;
        if (o >= 0 && o % PKT_LEN == 0)
            g = (k >= bad_lo && k <= bad_hi) ? 8'h00 : (k % 8 == 2 ? SYNC_INV : SYNC_BYTE);
        else g = filler();
        sp++;
        return g;
    endfunction

    task automatic run_bytes(int cnt, bit toggle);
        for (int i = 0; i < cnt; i++)
            if (toggle && i % 2 == 1) tick(1, 0, 8'($urandom));
            else tick(1, 1, gen());
    endtask

    task automatic restart(int ph);
        tick(0, 1, 8'h00);
        sp = 0; phase = ph; bad_lo = -1; bad_hi = -1;
    endtask

    initial begin
        bus.in_valid = 0;
        bus.data_in = 0;
        tbl[0] = '{0, 1, 8'h47, 0, 0, 8'd0, 0, 8'h00};
        tbl[1] = '{1, 1, 8'h12, 0, 0, 8'd0, 0, 8'h12};
        tbl[2] = '{1, 1, 8'h47, 0, 0, 8'd0, 0, 8'h47};
        tbl[3] = '{1, 1, 8'h33, 0, 0, 8'd1, 0, 8'h33};
        tbl[4] = '{1, 0, 8'h99, 0, 0, 8'd1, 0, 8'h33};
        tbl[5] = '{1, 1, 8'hB8, 0, 0, 8'd2, 0, 8'hB8};
        tbl[6] = '{0, 1, 8'h55, 0, 0, 8'd0, 0, 8'h00};
        tbl[7] = '{1, 1, 8'hB8, 0, 0, 8'd0, 0, 8'hB8};
        tbl[8] = '{1, 1, 8'h47, 0, 0, 8'd1, 0, 8'h47};
        for (int i = 0; i < 9; i++) begin
            tick(tbl[i].rn, tbl[i].v, tbl[i].d);
            check("tbl_out_valid", bus.out_valid, tbl[i].ov);
            check("tbl_sop", bus.sop, tbl[i].sop);
            check("tbl_byte_idx", bus.byte_idx, tbl[i].idx);
            check("tbl_locked", bus.locked, tbl[i].lk);
            check("tbl_data_out", bus.data_out, tbl[i].dout);
        end

        restart(5);
        cnt_a = 0;
        for (int i = 0; i < 413; i++) begin
            tick(1, 1, gen());
            cnt_a += int'(bus.out_valid);
        end
        check("ov_before_lock", cnt_a, 0);
        tick(1, 1, gen());
        check("lock_at_third_sync", {bus.locked, bus.out_valid, bus.sop}, 3'b111);
        check("lock_byte_idx", bus.byte_idx, 0);
        check("lock_frame_pos_inv", bus.frame_pos, 0);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 9 * PKT_LEN; i++) begin
            tick(1, 1, gen());
            cnt_a += int'(bus.sop);
            if (int'(bus.frame_pos) > cnt_b) cnt_b = int'(bus.frame_pos);
        end
        check("clean_sop_count", cnt_a, 9);
        check("clean_frame_pos_max", cnt_b, 7);

        restart(0);
        cnt_a = 0;
        for (int i = 0; i < 500; i++) begin
            tick(1, 1, i == 10 ? SYNC_BYTE : i == 214 ? 8'h00 : filler());
            if (i == 11) check("false_verify_idx", bus.byte_idx, 1);
            cnt_a += int'(bus.out_valid) + int'(bus.locked);
        end
        check("false_sync_never_locks", cnt_a, 0);

        restart(3);
        bad_lo = 4; bad_hi = 5;
        run_bytes(819, 0);
        tick(1, 1, gen());
        check("flywheel_miss_locked", {bus.locked, bus.sop}, 2'b11);
        check("flywheel_miss_idx", bus.byte_idx, 0);
        run_bytes(815, 0);
        bad_lo = 8; bad_hi = 10;
        run_bytes(408, 0);
        tick(1, 1, gen());
        check("third_miss_drops", {bus.locked, bus.out_valid, bus.sop}, 3'b000);
        bad_lo = -1; bad_hi = -1;
        run_bytes(700, 0);

        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 6 * PKT_LEN; i++) begin
            if (i % 2 == 1) tick(1, 0, 8'($urandom));
            else tick(1, 1, gen());
            cnt_a += int'(bus.sop);
            cnt_b += int'(bus.out_valid);
        end
        check("toggle_sop_count", cnt_a, 3);
        check("toggle_ov_count", cnt_b, 3 * PKT_LEN);

        n = 0;
        while (!(bus.locked && bus.byte_idx == 8'd100) && n < 500) begin
            tick(1, 1, gen());
            n++;
        end
        check("reach_idx100", {bus.locked, bus.byte_idx}, {1'b1, 8'd100});
        tick(0, 1, gen());
        check("mid_reset_outputs",
              {bus.data_out, bus.out_valid, bus.sop, bus.byte_idx, bus.frame_pos, bus.locked}, 0);
        n = 0;
        while (!bus.locked && n < 1000) begin
            tick(1, 1, gen());
            n++;
        end
        check("relock_ticks_after_reset", n, 511);

        tick(1, 1, filler());
        n = 0;
        while (bus.locked && n < 1000) begin
            tick(1, 1, gen());
            n++;
        end
        check("slip_unlocks", bus.locked, 0);
        n = 0;
        while (!bus.locked && n < 1000) begin
            tick(1, 1, gen());
            n++;
        end
        check("slip_relock_ticks", n, 409);
        check("slip_relock_sop", {bus.sop, bus.byte_idx}, {1'b1, 8'd0});

        restart(int'($urandom_range(0, PKT_LEN - 1)));
        cnt_a = 0;
        for (int i = 0; i < 20000; i++) begin
            r = int'($urandom_range(0, 9999));
            if (r == 0) tick(0, 1, 8'h00);
            else if (r == 1) tick(1, 1, filler());
            else if (r < 2500) tick(1, 0, 8'($urandom));
            else begin
                b = gen();
                if (b == SYNC_BYTE || b == SYNC_INV) begin
                    if ($urandom_range(0, 7) == 0) b = 8'h00;
                end else if ($urandom_range(0, 299) == 0) b = SYNC_BYTE;
                tick(1, 1, b);
            end
            cnt_a += int'(bus.locked);
        end
        check("random_reached_lock", int'(cnt_a > 0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/packet_sync_detector.md
# packet_sync_detector

Downstream neighbour of the convolutional deinterleaver (I=12, M=17) in the DVB receive chain; consumes its byte stream and recovers 204-byte RS packet framing before the RS(204,188) decoder. Hunts for sync bytes (0x47, or inverted 0xB8 at each 8-packet superframe start) on a 204-byte grid, locks after repeated hits and flywheels through isolated misses. Emits the registered byte stream with packet-start, byte index, superframe position and lock status.

## Interface
- PKT_LEN, 204, bytes per packet, sync byte included
- SYNC_BYTE, 8'h47, normal sync byte
- SYNC_INV, 8'hB8, inverted sync byte marking superframe start
- LOCK_CNT, 3, consecutive on-grid sync hits, first one included, needed to lock
- UNLOCK_CNT, 3, consecutive on-grid misses in LOCKED that drop lock
- clk  input  1  single clock, all logic rising-edge
- reset  input  1  synchronous, active-low reset
- data_in  input  8  byte from deinterleaver output
- in_valid  input  1  data_in qualifier; tied high when the deinterleaver runs every cycle
- data_out  output  8  data_in delayed one cycle, passed regardless of lock
- out_valid  output  1  registered in_valid AND lock state at that byte
- sop  output  1  marks the byte at packet position 0; only asserted while locked
- byte_idx  output  8  position of data_out in packet, 0..PKT_LEN-1
- frame_pos  output  3  packet index in superframe, 0 on an inverted-sync packet
- locked  output  1  high while state is LOCKED

## Operation
- States: SEARCH, VERIFY, LOCKED. Nothing changes when in_valid=0: counters, state and outputs hold, out_valid=0, sop=0.
- Sync hit: data_in == SYNC_BYTE or SYNC_INV.
- SEARCH: on a hit, go to VERIFY, pos=1, hits=1. Otherwise stay.
- VERIFY: pos counts 0..PKT_LEN-1 and wraps. At pos==0: on a hit, hits++ and go to LOCKED when hits reaches LOCK_CNT. On a miss, go to SEARCH; the missed byte is not re-examined as a new candidate. Bytes off position 0 are ignored.
- LOCKED: pos keeps wrapping. At pos==0:
  - hit clears miss_cnt;
  - miss increments miss_cnt, and at UNLOCK_CNT goes to SEARCH;
  - sop is asserted at pos 0 whether hit or miss (flywheel).
- frame_pos: forced to 0 at pos 0 when data_in==SYNC_INV, else +1 mod 8 at each pos 0 while in VERIFY/LOCKED; 0 in SEARCH.
- Drop of lock: the byte that causes it is output with out_valid=0 and locked=0.
- LOCK_CNT=1 case: the first hit locks directly from SEARCH.

## Timing
- Latency is 1 cycle for all outputs; every output is registered.
- data_out/byte_idx/sop/frame_pos/locked all describe the same byte.
- With default parameters, sync at input cycles t, t+204, t+408 gives locked=1, out_valid=1, sop=1, byte_idx=0 at t+409. Before that, out_valid=0.
- Reset values: data_out=0, out_valid=0, sop=0, byte_idx=0, frame_pos=0, locked=0, state SEARCH, internal counters 0.
- Reset mid-operation takes effect on the next edge and discards lock; no partial packet is flagged.
- in_valid gaps stretch the grid: pos advances only on valid bytes.

## Structure
- Shared package dvb_rx_pkg holds:
  - PKT_LEN, SYNC_BYTE and SYNC_INV constants;
  - the state enum {SEARCH, VERIFY, LOCKED};
  - superframe length 8.
- Sub-module pkt_pos_counter: mod-PKT_LEN counter with enable, load-to-1 and clear, exposing pos and the wrap flag pos==0. The FSM, hit/miss counters and output register stay in the top.

## Test plan
- Clean stream: 0x47 every 204 bytes from cycle 5, with 0xB8 every 8th packet → locked at the third sync output. sop every 204 valid outputs; frame_pos 0 on the 0xB8 packet and increments to 7.
- False sync: isolated 0x47 at cycle 10, next on-grid byte 0x00 → back to SEARCH, locked stays 0, out_valid stays 0.
- Flywheel: locked stream with 2 consecutive sync bytes corrupted to 0x00 → locked stays 1 and sop still asserted at byte_idx 0. A third consecutive corruption drops locked on that byte's output.
- in_valid toggling 1/0 on a locked stream → byte_idx advances only on valid bytes, sop spacing is 204 valid bytes, out_valid=0 on idle cycles.
- reset=0 for one cycle while locked at byte_idx 100 → next cycle all outputs 0, and relock needs 3 fresh hits.
- Shifted grid: lock, then insert 1 extra byte → 3 misses, unlock, relock on the new alignment after 3 further packets.
